mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/tron_mem_pkg.sv | 25 ++
 rtl/mem_wait_counter.sv | 29 ++
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, opcode field positions
// and wait-state limits used by mem_responder and mem_wait_counter.
package tron_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    // WAIT_CYCLES must stay inside 1..15 so it fits the 4-bit down-counter
    localparam int WAIT_MIN  = 1;
    localparam int WAIT_MAX  = 15;
    localparam int CNT_BITS  = 4;

    localparam int OP_HI_MSB = 15;
    localparam int OP_HI_LSB = 12;
    localparam int OP_LO_MSB = 7;
    localparam int OP_LO_LSB = 4;

    function automatic logic [7:0] op_field(input logic [15:0] instr);
        return {instr[OP_HI_MSB:OP_HI_LSB], instr[OP_LO_MSB:OP_LO_LSB]};
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loaded on request accept, decremented while the
// access is in progress, flags zero when the memory access may complete.
module mem_wait_counter
    import tron_mem_pkg::*;
#(
    parameter int LOAD_VALUE = WAIT_MIN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    logic [CNT_BITS-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_BITS'(LOAD_VALUE);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one controller request at a time and runs it against a
// synchronous RAM with WAIT_CYCLES extra wait states. Define MEM_RESP_ERR_EN for range checking.
module mem_responder
    import tron_mem_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR_BITS   = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_WORDS   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_fetch,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 resp_valid,
    output logic [WIDTH-1:0]     resp_rdata,
    output logic [WIDTH-1:0]     instruction,
    output logic [7:0]           instructionOp,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                 resp_err
`endif
);

    mem_state_e r_state;
    mem_state_e w_next_state;

    logic                 r_write;
    logic                 r_fetch;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [WIDTH-1:0]     r_mem_wdata;
    logic                 r_mem_en;
    logic                 r_mem_we;
    logic [WIDTH-1:0]     r_resp_rdata;
    logic [WIDTH-1:0]     r_instruction;

    logic w_accept;
    logic w_addr_err;
    logic w_in_access;
    logic w_cnt_zero;
    logic w_read_done;

    assign req_ready   = (r_state == ST_IDLE) && reset;
    assign w_accept    = req_valid && req_ready;
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_read_done = w_in_access && w_cnt_zero && !r_write;

`ifdef MEM_RESP_ERR_EN
    assign w_addr_err = (32'(req_addr) >= 32'(MEM_WORDS));
`else
    assign w_addr_err = 1'b0;
`endif

    mem_wait_counter #(
        .LOAD_VALUE (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_dec  (w_in_access),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Out-of-range requests bypass ACCESS so the RAM never sees them
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_addr_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write       <= 1'b0;
            r_fetch       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_resp_rdata  <= '0;
            r_instruction <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (w_accept) begin
                r_write     <= req_write;
                r_fetch     <= req_fetch && !req_write;
                r_mem_addr  <= req_addr;
                r_mem_wdata <= req_wdata;
                r_mem_en    <= !w_addr_err;
                r_mem_we    <= req_write && !w_addr_err;
                if (w_addr_err) begin
                    r_resp_rdata <= '0;
                end
            end
            if (w_read_done) begin
                r_resp_rdata <= mem_rdata;
                if (r_fetch) begin
                    r_instruction <= mem_rdata;
                end
            end
        end
    end

`ifdef MEM_RESP_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_addr_err;
        end
    end

    assign resp_err = r_err && (r_state == ST_RESP);
`endif

    assign resp_valid    = (r_state == ST_RESP);
    assign resp_rdata    = r_resp_rdata;
    assign instruction   = r_instruction;
    assign instructionOp = op_field(r_instruction[15:0]);
    assign mem_addr      = r_mem_addr;
    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: table of directed requests on a WAIT_CYCLES=1 instance,
// plus reset-abort, back-to-back (WAIT_CYCLES=3) and optional MEM_RESP_ERR_EN sequences.
module tb_mem_responder;

    typedef struct {
        logic        write;
        logic        fetch;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
        logic [15:0] expInstr;
        logic [7:0]  expOp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic        reqValidA, reqWriteA, reqFetchA, reqReadyA, respValidA, memEnA, memWeA;
    logic [15:0] reqAddrA, reqWdataA, respRdataA, instructionA, memAddrA, memWdataA, memRdataA;
    logic [7:0]  instructionOpA;

    logic        reqValidB, reqWriteB, reqFetchB, reqReadyB, respValidB, memEnB, memWeB;
    logic [15:0] reqAddrB, reqWdataB, respRdataB, instructionB, memAddrB, memWdataB, memRdataB;
    logic [7:0]  instructionOpB;

`ifdef MEM_RESP_ERR_EN
    logic respErrA, respErrB;
`endif

    mem_responder #(.WIDTH(16), .ADDR_BITS(16), .WAIT_CYCLES(1), .MEM_WORDS(1024)) dutA (
        .clk(clk), .reset(reset),
        .req_valid(reqValidA), .req_ready(reqReadyA), .req_write(reqWriteA), .req_fetch(reqFetchA),
        .req_addr(reqAddrA), .req_wdata(reqWdataA),
        .resp_valid(respValidA), .resp_rdata(respRdataA),
        .instruction(instructionA), .instructionOp(instructionOpA),
        .mem_addr(memAddrA), .mem_en(memEnA), .mem_we(memWeA), .mem_wdata(memWdataA),
        .mem_rdata(memRdataA)
`ifdef MEM_RESP_ERR_EN
        , .resp_err(respErrA)
`endif
    );

    mem_responder #(.WIDTH(16), .ADDR_BITS(16), .WAIT_CYCLES(3), .MEM_WORDS(1024)) dutB (
        .clk(clk), .reset(reset),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_write(reqWriteB), .req_fetch(reqFetchB),
        .req_addr(reqAddrB), .req_wdata(reqWdataB),
        .resp_valid(respValidB), .resp_rdata(respRdataB),
        .instruction(instructionB), .instructionOp(instructionOpB),
        .mem_addr(memAddrB), .mem_en(memEnB), .mem_we(memWeB), .mem_wdata(memWdataB),
        .mem_rdata(memRdataB)
`ifdef MEM_RESP_ERR_EN
        , .resp_err(respErrB)
`endif
    );

    // Synchronous RAM models; a few words are preloaded while reset is held
    logic [15:0] ramA [0:1023];
    logic [15:0] ramB [0:1023];

    always @(posedge clk) begin
        if (!reset) begin
            ramA[16'h0010] <= 16'h5123;
            ramA[16'h0030] <= 16'hCAFE;
            ramA[16'h03FF] <= 16'h9A3C;
        end else if (memEnA) begin
            if (memWeA) ramA[memAddrA[9:0]] <= memWdataA;
            memRdataA <= ramA[memAddrA[9:0]];
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            ramB[5] <= 16'h4242;
            ramB[6] <= 16'h1111;
            ramB[7] <= 16'h2222;
        end else if (memEnB) begin
            if (memWeB) ramB[memAddrB[9:0]] <= memWdataB;
            memRdataB <= ramB[memAddrB[9:0]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One request on dutA; inputs are scrambled after accept to prove they were latched
    task automatic applyStimulus(input vec_t v);
        int          lat;
        int          enCount;
        int          readyHigh;
        logic        seenWe;
        logic [15:0] seenAddr;
        logic [15:0] seenWdata;
        lat = 0; enCount = 0; readyHigh = 0;
        seenWe = 1'b0; seenAddr = 16'h0; seenWdata = 16'h0;
        @(negedge clk);
        checkOutput("ready before request", {31'd0, reqReadyA}, 32'd1);
        reqValidA = 1'b1; reqWriteA = v.write; reqFetchA = v.fetch;
        reqAddrA = v.addr; reqWdataA = v.wdata;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (memEnA) begin
                enCount++;
                seenWe = memWeA; seenAddr = memAddrA; seenWdata = memWdataA;
            end
            if (reqReadyA) readyHigh++;
            if (k == 1) begin
                reqValidA = 1'b0; reqWriteA = ~v.write; reqFetchA = ~v.fetch;
                reqAddrA = 16'h00FF; reqWdataA = 16'h5555;
            end
            if (respValidA) begin
                lat = k;
                break;
            end
        end
        checkOutput("latency", lat, 3);
        checkOutput("mem_en pulses", enCount, 1);
        checkOutput("mem_we", {31'd0, seenWe}, {31'd0, v.write});
        checkOutput("mem_addr", {16'd0, seenAddr}, {16'd0, v.addr});
        if (v.write) checkOutput("mem_wdata", {16'd0, seenWdata}, {16'd0, v.wdata});
        checkOutput("ready while busy", readyHigh, 0);
        checkOutput("resp_rdata", {16'd0, respRdataA}, {16'd0, v.expRdata});
        checkOutput("instruction", {16'd0, instructionA}, {16'd0, v.expInstr});
        checkOutput("instructionOp", {24'd0, instructionOpA}, {24'd0, v.expOp});
        @(negedge clk);
        checkOutput("resp_valid one cycle", {31'd0, respValidA}, 32'd0);
        checkOutput("ready after resp", {31'd0, reqReadyA}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [9];
        vec_t        again;
        logic [15:0] addrsB [3];
        logic [15:0] expB [3];
        int          accB [3];
        int          idx;
        int          respIdx;
        int          readyCount;
        int          respCount;
        int          readyHigh;
        logic        pending;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5123, 16'h5123, 8'h52};
        vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h5123, 16'h5123, 8'h52};
        vecs[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 16'h5123, 8'h52};
        vecs[3] = '{1'b1, 1'b1, 16'h0021, 16'h7777, 16'hBEEF, 16'h5123, 8'h52};
        vecs[4] = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'h7777, 16'h7777, 8'h77};
        vecs[5] = '{1'b0, 1'b1, 16'h0030, 16'h0000, 16'hCAFE, 16'hCAFE, 8'hCF};
        vecs[6] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h9A3C, 16'hCAFE, 8'hCF};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'h9A3C, 16'hCAFE, 8'hCF};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 8'h00};

        reqValidA = 1'b0; reqWriteA = 1'b0; reqFetchA = 1'b0; reqAddrA = 16'h0; reqWdataA = 16'h0;
        reqValidB = 1'b0; reqWriteB = 1'b0; reqFetchB = 1'b0; reqAddrB = 16'h0; reqWdataB = 16'h0;

        #2 reset = 1'b0;
        reqValidA = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ready", {31'd0, reqReadyA}, 32'd0);
        checkOutput("reset resp_valid", {31'd0, respValidA}, 32'd0);
        checkOutput("reset mem_en", {31'd0, memEnA}, 32'd0);
        checkOutput("reset resp_rdata", {16'd0, respRdataA}, 32'd0);
        checkOutput("reset instruction", {16'd0, instructionA}, 32'd0);
        reqValidA = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Abort a fetch in its second ACCESS cycle
        @(negedge clk);
        reqValidA = 1'b1; reqWriteA = 1'b0; reqFetchA = 1'b1; reqAddrA = 16'h0030;
        @(negedge clk);
        reqValidA = 1'b0;
        checkOutput("abort first access mem_en", {31'd0, memEnA}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort resp_rdata", {16'd0, respRdataA}, 32'd0);
        checkOutput("abort instruction", {16'd0, instructionA}, 32'd0);
        checkOutput("abort instructionOp", {24'd0, instructionOpA}, 32'd0);
        checkOutput("abort ready", {31'd0, reqReadyA}, 32'd0);
        checkOutput("abort mem_addr", {16'd0, memAddrA}, 32'd0);
        checkOutput("abort resp_valid", {31'd0, respValidA}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        respCount = 0; readyHigh = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (respValidA) respCount++;
            if (reqReadyA) readyHigh++;
        end
        checkOutput("no resp after abort", respCount, 0);
        checkOutput("idle after abort", readyHigh, 6);
        again = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5123, 16'h5123, 8'h52};
        applyStimulus(again);

        // Back-to-back loads on the WAIT_CYCLES=3 instance with valid held high
        addrsB[0] = 16'd5;    addrsB[1] = 16'd6;    addrsB[2] = 16'd7;
        expB[0]   = 16'h4242; expB[1]   = 16'h1111; expB[2]   = 16'h2222;
        accB[0] = 0; accB[1] = 0; accB[2] = 0;
        idx = 0; respIdx = 0; readyCount = 0; pending = 1'b0;
        @(negedge clk);
        reqValidB = 1'b1; reqWriteB = 1'b0; reqFetchB = 1'b0; reqAddrB = addrsB[0];
        for (int cyc = 0; cyc < 60 && respIdx < 3; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                if (idx == 3) reqValidB = 1'b0;
                else reqAddrB = addrsB[idx];
            end
            if (respValidB && respIdx < idx) begin
                checkOutput("b2b resp_rdata", {16'd0, respRdataB}, {16'd0, expB[respIdx]});
                checkOutput("b2b latency", cyc - accB[respIdx], 5);
                respIdx++;
            end
            if (reqReadyB) readyCount++;
            if (reqReadyB && reqValidB && idx < 3) begin
                accB[idx] = cyc;
                if (idx > 0) checkOutput("b2b spacing", accB[idx] - accB[idx-1], 6);
                idx++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("b2b accepts", idx, 3);
        checkOutput("b2b responses", respIdx, 3);
        checkOutput("b2b ready cycles", readyCount, 3);
        reqValidB = 1'b0;

`ifdef MEM_RESP_ERR_EN
        begin
            int lat;
            int enCount;
            lat = 0; enCount = 0;
            @(negedge clk);
            reqValidA = 1'b1; reqWriteA = 1'b0; reqFetchA = 1'b1; reqAddrA = 16'h0400;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                reqValidA = 1'b0;
                if (memEnA) enCount++;
                if (respValidA) begin
                    lat = k;
                    checkOutput("err resp_err", {31'd0, respErrA}, 32'd1);
                    break;
                end
            end
            checkOutput("err latency", lat, 1);
            checkOutput("err mem_en", enCount, 0);
            checkOutput("err resp_rdata", {16'd0, respRdataA}, 32'd0);
            checkOutput("err instruction", {16'd0, instructionA}, 32'h5123);
        end
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
